time_entry_loader: RTL
======================

Name: time_entry_loader

Overview:
- Keypad-side front end of the microwave timer; sits directly upstream of the seconds-units, seconds-tens (mod-6), minutes-units and minutes-tens down counters.
- Debounces keypad digit presses and shifts them into a 4-digit MM:SS entry buffer.
- On a start request, validates the entry, drives the buffer onto the counters' parallel data inputs and pulses their active-low load strobe for one clock.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles key_valid must be high before a key is accepted (legal range 1 to 2^CNT_W-1).
- CNT_W, 16, width of the debounce counter.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- clr  in  1  asynchronous active-high reset.
- key_valid  in  1  keypad encoder "key held" level, already synchronous to clock.
- key_code  in  4  code of the held key: 0-9 are digits, 10 is CLEAR, 11-15 are ignored.
- start  in  1  start button level, already synchronous to clock.
- busy  in  1  high while the countdown is running; blocks entry and start.
- loadn  out  1  active-low load strobe to all four counters.
- sec_ones  out  4  entry digit / data to the seconds-units counter.
- sec_tens  out  4  entry digit / data to the seconds-tens (mod-6) counter.
- min_ones  out  4  entry digit / data to the minutes-units counter.
- min_tens  out  4  entry digit / data to the minutes-tens counter.
- digit_count  out  3  number of digits entered, 0-4, saturating.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (clr=1, asynchronous): all four digits = 0; digit_count = 0; loadn = 1; err = 0; state = IDLE; debounce counter = 0; start edge register = 0.
- All outputs are registered.
- Start edge: start_rise = start & ~start_d, where start_d is registered every cycle in every state.
- FSM states: IDLE, DEBOUNCE, WAIT_RELEASE, LOAD.
- IDLE:
  - start_rise & ~busy & digit_count>0: if sec_tens ≤ 5, go to LOAD; otherwise err=1 for the next cycle, buffer unchanged, stay in IDLE.
  - start_rise with busy=1 or digit_count=0 is ignored.
  - Otherwise, key_valid & ~busy: go to DEBOUNCE with counter=1.
  - start_rise takes priority over key_valid in the same cycle.
- DEBOUNCE:
  - key_valid=0 or busy=1: return to IDLE, no capture.
  - Otherwise, if counter ≥ DEBOUNCE_CYCLES: capture key_code and go to WAIT_RELEASE. Else increment the counter.
  - With DEBOUNCE_CYCLES=1, capture occurs on the first DEBOUNCE cycle.
- Capture actions:
  - Digit 0-9: min_tens←min_ones, min_ones←sec_tens, sec_tens←sec_ones, sec_ones←key_code. digit_count increments and saturates at 4. On a 5th or later digit the oldest digit is discarded.
  - CLEAR (10): all digits = 0, digit_count = 0.
  - Codes 11-15: no change.
- WAIT_RELEASE: stay until key_valid=0, then go to IDLE. Exactly one capture per press, however long the key is held. busy does not affect this state.
- LOAD (exactly one cycle):
  - loadn=0 during this cycle; the digit outputs hold the entry unchanged, so counters sample valid data on the edge ending LOAD.
  - Next cycle: loadn=1, all digits cleared to 0, digit_count=0, state IDLE.
- err is high only in the single cycle after the rejecting edge; loadn remains 1 in that case.
- No validation on minutes digits or sec_ones (all 0-9 by construction).
- Reset mid-operation (any state, including LOAD): immediately apply reset values; loadn returns to 1 asynchronously.
- A key held across a reset: after clr deasserts, a still-high key_valid is treated as a new press.

Test Plan:
- Reset, then press keys 1,3,0 (each key_valid high for 6 cycles, low for 3) -> min_tens=0, min_ones=1, sec_tens=3, sec_ones=0, digit_count=3; loadn stays 1.
- Key 7 with key_valid high for only 3 cycles (DEBOUNCE_CYCLES=4) -> no capture, digit_count unchanged. Key 7 held for 50 cycles -> exactly one capture.
- Enter 1,2,3,4,5 -> buffer 2,3,4,5 (MM=23, SS=45), digit_count=4. Then key 10 -> all zeros, digit_count=0.
- Enter 0,2,5,9, then pulse start -> loadn=0 for exactly one cycle with min_tens=0, min_ones=2, sec_tens=5, sec_ones=9. Next cycle: loadn=1, buffer=0, digit_count=0.
- Enter 1,7,0 (sec_tens=7), then start -> err=1 for one cycle, loadn never 0, buffer retained. Start with digit_count=0 -> no response. Start or keypress with busy=1 -> ignored.
- Assert clr during LOAD, and separately during DEBOUNCE -> loadn=1 and all outputs 0 immediately. With key_valid still high after clr release -> fresh debounce and capture.

Source files
------------

// File: rtl/time_entry_loader_if.sv
// Keypad/start inputs and counter-load outputs of the microwave timer
// entry front end, bundled as one interface.
interface time_entry_loader_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start;
  logic       busy;
  logic       loadn;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic [2:0] digit_count;
  logic       err;

  modport master (
    output key_valid,
    output key_code,
    output start,
    output busy,
    input  loadn,
    input  sec_ones,
    input  sec_tens,
    input  min_ones,
    input  min_tens,
    input  digit_count,
    input  err
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  start,
    input  busy,
    output loadn,
    output sec_ones,
    output sec_tens,
    output min_ones,
    output min_tens,
    output digit_count,
    output err
  );
endinterface

// File: rtl/time_entry_loader.sv
// Debounced keypad entry into an MM:SS buffer, validated and
// parallel-loaded into the countdown counters on start.
module time_entry_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic               clock,
  input  logic               clr,
  time_entry_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    WAIT_RELEASE,
    LOAD
  } state_t;

  localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);
  localparam logic [3:0]       KEY_CL = 4'd10;
  localparam logic [3:0]       MAX_ST = 4'd5;
  localparam logic [2:0]       MAX_DC = 3'd4;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             start_d;
  logic             start_rise;

  logic [3:0] s1, s1_n;
  logic [3:0] s10, s10_n;
  logic [3:0] m1, m1_n;
  logic [3:0] m10, m10_n;
  logic [2:0] dc, dc_n;
  logic       ld_n, ld_nn;
  logic       er, er_n;

  assign start_rise = bus.start & ~start_d;

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      start_d <= 1'b0;
      s1      <= '0;
      s10     <= '0;
      m1      <= '0;
      m10     <= '0;
      dc      <= '0;
      ld_n    <= 1'b1;
      er      <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      start_d <= bus.start;
      s1      <= s1_n;
      s10     <= s10_n;
      m1      <= m1_n;
      m10     <= m10_n;
      dc      <= dc_n;
      ld_n    <= ld_nn;
      er      <= er_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    s1_n    = s1;
    s10_n   = s10;
    m1_n    = m1;
    m10_n   = m10;
    dc_n    = dc;
    ld_nn   = 1'b1;
    er_n    = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        // a valid start outranks a key arriving in the same cycle
        if (start_rise && !bus.busy && dc != 3'd0) begin
          if (s10 <= MAX_ST) begin
            state_n = LOAD;
            ld_nn   = 1'b0;
          end else begin
            er_n = 1'b1;
          end
        end else if (bus.key_valid && !bus.busy) begin
          state_n = DEBOUNCE;
          cnt_n   = CNT_1;
        end
      end

      DEBOUNCE: begin
        if (!bus.key_valid || bus.busy) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt >= DB_LIM) begin
          state_n = WAIT_RELEASE;
          cnt_n   = '0;
          unique case (1'b1)
            (bus.key_code < KEY_CL): begin
              m10_n = m1;
              m1_n  = s10;
              s10_n = s1;
              s1_n  = bus.key_code;
              if (dc < MAX_DC) dc_n = dc + 3'd1;
            end
            (bus.key_code == KEY_CL): begin
              s1_n  = '0;
              s10_n = '0;
              m1_n  = '0;
              m10_n = '0;
              dc_n  = '0;
            end
            default: ;
          endcase
        end else begin
          cnt_n = cnt + CNT_1;
        end
      end

      WAIT_RELEASE: begin
        if (!bus.key_valid) state_n = IDLE;
      end

      LOAD: begin
        // counters sampled the buffer on the edge ending this cycle
        state_n = IDLE;
        s1_n    = '0;
        s10_n   = '0;
        m1_n    = '0;
        m10_n   = '0;
        dc_n    = '0;
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.loadn       = ld_n;
  assign bus.err         = er;
  assign bus.sec_ones    = s1;
  assign bus.sec_tens    = s10;
  assign bus.min_ones    = m1;
  assign bus.min_tens    = m10;
  assign bus.digit_count = dc;

endmodule
